// File: rtl/mc_control_fsm.sv
// Multicycle RV32 main controller: Moore sequencing FSM with combinational
// ALU and immediate decoders, a sticky illegal-opcode flag and a retire counter.
module mc_control_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 Zero,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [2:0]           ALUControl,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 AdrSrc,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic [3:0]           state,
  output logic                 illegal,
  output logic [INSTRET_W-1:0] instret
);

  // state    | meaning
  // FETCH    | read instr at PC, PC <= PC+4
  // DECODE   | read regs, form branch target
  // MEMADR   | rs1 + imm address
  // MEMREAD  | load data read
  // MEMWB    | load writeback
  // MEMWRITE | store data write
  // EXECR    | R-type ALU op
  // EXECI    | I-type ALU op
  // ALUWB    | ALU result writeback
  // JAL      | PC <= target, link = OldPC+4
  // BEQ      | compare, conditional PC write
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  state_t     state_q, state_d;
  logic       op_legal;
  logic       retire;
  logic [1:0] alu_op;
  logic       pc_update, branch;
  logic       reg_write_s, ir_write_s, mem_write_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ: op_legal = 1'b1;
      default:                                 op_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECR;
          OP_I:         state_d = S_EXECI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_BEQ:      state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    AdrSrc      = 1'b0;
    alu_op      = 2'b00;
    pc_update   = 1'b0;
    branch      = 1'b0;
    reg_write_s = 1'b0;
    ir_write_s  = 1'b0;
    mem_write_s = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_s = 1'b1;
        ALUSrcB    = 2'b10;
        ResultSrc  = 2'b10;
        pc_update  = 1'b1;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        reg_write_s = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        mem_write_s = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB: reg_write_s = 1'b1;
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset asserts asynchronously mid-cycle; gate enables so FETCH defaults
  // cannot leak a write while reset is held.
  assign RegWrite = reg_write_s & ~reset;
  assign IRWrite  = ir_write_s  & ~reset;
  assign MemWrite = mem_write_s & ~reset;
  assign PCWrite  = (pc_update | (branch & Zero)) & ~reset;

  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      default: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
    endcase
  end

  // Every retiring state exits straight to FETCH, so retire = in that state.
  assign retire = (state_q == S_MEMWB) || (state_q == S_MEMWRITE) ||
                  (state_q == S_ALUWB) || (state_q == S_BEQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      illegal <= 1'b0;
      instret <= '0;
    end else begin
      if (state_q == S_DECODE && !op_legal) illegal <= 1'b1;
      if (retire) instret <= instret + INSTRET_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm with a 4-bit retire counter so wrap is reachable.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic [1:0] ResultSrc, ImmSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl;
  logic       AdrSrc, RegWrite, IRWrite, PCWrite, MemWrite;
  logic [3:0] state;
  logic       illegal;
  logic [3:0] instret;

  int total = 0;
  int bad   = 0;

  mc_control_fsm #(.INSTRET_W(4)) dut (
    .clk(clk), .reset(reset), .op(op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .AdrSrc(AdrSrc), .RegWrite(RegWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .MemWrite(MemWrite), .state(state),
    .illegal(illegal), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; op = 7'b0; funct3 = 3'b0; funct7b5 = 1'b0; Zero = 1'b0;

    // T1 reset
    repeat (3) tick();
    chk("rst_state", 32'(state), 0);
    chk("rst_enables", 32'({RegWrite, IRWrite, PCWrite, MemWrite}), 0);
    chk("rst_instret", 32'(instret), 0);
    chk("rst_illegal", 32'(illegal), 0);
    reset = 1'b0; op = 7'b0000011;
    #1;
    chk("fetch_irwrite", 32'(IRWrite), 1);
    chk("fetch_pcwrite", 32'(PCWrite), 1);
    chk("fetch_srcb", 32'(ALUSrcB), 2);
    chk("fetch_result", 32'(ResultSrc), 2);

    // T2 lw
    tick(); chk("lw_s1", 32'(state), 1);
    chk("dec_srca", 32'(ALUSrcA), 1);
    chk("dec_pcwrite", 32'(PCWrite), 0);
    tick(); chk("lw_s2", 32'(state), 2);
    chk("memadr_srca", 32'(ALUSrcA), 2);
    tick(); chk("lw_s3", 32'(state), 3);
    chk("memread_adr", 32'(AdrSrc), 1);
    chk("memread_regw", 32'(RegWrite), 0);
    tick(); chk("lw_s4", 32'(state), 4);
    chk("memwb_regw", 32'(RegWrite), 1);
    chk("memwb_result", 32'(ResultSrc), 1);
    chk("lw_instret_pre", 32'(instret), 0);
    op = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;
    tick(); chk("lw_s0", 32'(state), 0);
    chk("lw_instret", 32'(instret), 1);

    // T3 R-type sub, plus funct3 decode while in EXECR
    tick(); chk("r_s1", 32'(state), 1);
    tick(); chk("r_s6", 32'(state), 6);
    chk("r_sub", 32'(ALUControl), 1);
    chk("r_srcb", 32'(ALUSrcB), 0);
    funct7b5 = 1'b0; #1 chk("r_add", 32'(ALUControl), 0);
    funct3 = 3'b010; #1 chk("r_slt", 32'(ALUControl), 5);
    funct3 = 3'b110; #1 chk("r_or", 32'(ALUControl), 3);
    funct3 = 3'b111; #1 chk("r_and", 32'(ALUControl), 2);
    funct3 = 3'b000; funct7b5 = 1'b1;
    tick(); chk("r_s7", 32'(state), 7);
    chk("aluwb_regw", 32'(RegWrite), 1);
    op = 7'b0010011;
    tick(); chk("r_s0", 32'(state), 0);
    chk("r_instret", 32'(instret), 2);

    // I-type: funct7b5 set but op[5]=0, so add
    tick(); chk("i_s1", 32'(state), 1);
    tick(); chk("i_s8", 32'(state), 8);
    chk("i_add", 32'(ALUControl), 0);
    chk("i_srcb", 32'(ALUSrcB), 1);
    tick(); chk("i_s7", 32'(state), 7);
    op = 7'b1100011; Zero = 1'b1;
    tick(); chk("i_instret", 32'(instret), 3);

    // T4 beq taken / not taken
    tick(); chk("beq_s1", 32'(state), 1);
    tick(); chk("beq_s10", 32'(state), 10);
    chk("beq_sub", 32'(ALUControl), 1);
    chk("beq_imm", 32'(ImmSrc), 2);
    chk("beq_taken", 32'(PCWrite), 1);
    Zero = 1'b0; #1 chk("beq_nottaken", 32'(PCWrite), 0);
    tick(); chk("beq_s0", 32'(state), 0);
    chk("beq_instret", 32'(instret), 4);
    tick(); tick(); chk("beq2_s10", 32'(state), 10);
    chk("beq2_pcwrite", 32'(PCWrite), 0);
    op = 7'b1101111;
    tick(); chk("beq2_instret", 32'(instret), 5);

    // T5 jal then illegal
    tick(); chk("jal_s1", 32'(state), 1);
    tick(); chk("jal_s9", 32'(state), 9);
    chk("jal_pcwrite", 32'(PCWrite), 1);
    chk("jal_imm", 32'(ImmSrc), 3);
    chk("jal_srcb", 32'(ALUSrcB), 2);
    tick(); chk("jal_s7", 32'(state), 7);
    op = 7'b0000000;
    tick(); chk("jal_instret", 32'(instret), 6);
    chk("pre_illegal", 32'(illegal), 0);
    tick(); chk("ill_s1", 32'(state), 1);
    op = 7'b0110011; #1;
    op = 7'b0000000;
    tick(); chk("ill_s0", 32'(state), 0);
    chk("ill_flag", 32'(illegal), 1);
    chk("ill_instret", 32'(instret), 6);
    op = 7'b0110011;
    tick(); tick(); chk("ill_sticky", 32'(illegal), 1);
    chk("ill_next_s6", 32'(state), 6);

    // T6 reset, then 16 stores wrap the 4-bit counter
    reset = 1'b1; #1;
    chk("rst2_state", 32'(state), 0);
    chk("rst2_illegal", 32'(illegal), 0);
    chk("rst2_instret", 32'(instret), 0);
    tick(); reset = 1'b0; op = 7'b0100011;
    for (int i = 0; i < 16; i++) begin
      tick(); chk("sw_s1", 32'(state), 1);
      tick(); chk("sw_s2", 32'(state), 2);
      chk("sw_memw_off", 32'(MemWrite), 0);
      tick(); chk("sw_s5", 32'(state), 5);
      chk("sw_memw", 32'(MemWrite), 1);
      chk("sw_adr", 32'(AdrSrc), 1);
      chk("sw_imm", 32'(ImmSrc), 1);
      tick(); chk("sw_s0", 32'(state), 0);
      chk("sw_instret", 32'(instret), 32'((i + 1) % 16));
    end
    chk("sw_wrap", 32'(instret), 0);

    // reset asserted in MEMADR
    tick(); tick(); chk("mid_s2", 32'(state), 2);
    reset = 1'b1; #1;
    chk("mid_state", 32'(state), 0);
    chk("mid_enables", 32'({RegWrite, IRWrite, PCWrite, MemWrite}), 0);
    tick(); chk("mid_hold_state", 32'(state), 0);
    chk("mid_hold_memw", 32'(MemWrite), 0);
    tick(); reset = 1'b0; #1;
    chk("mid_rel_state", 32'(state), 0);
    chk("mid_rel_irwrite", 32'(IRWrite), 1);
    chk("mid_instret", 32'(instret), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
